lsu_responder: RTL and testbench

LSU_RESPONDER -- requirements
Module: lsu_responder

---
 rtl/lsu_responder.sv | 189 ++++++++++++++++++
 tb/tb_lsu_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_responder.sv
// Load/store responder: takes one decoded memory access at a time, checks it
// for legality, issues a single aligned doubleword transaction and, for loads,
// extracts and extends the addressed field.
module lsu_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        rd_mem_en,
  input  logic        wr_mem_en,
  input  logic [3:0]  wr_rd_mem_len,
  input  logic [6:0]  rd_mem_op,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [4:0]  rd_idx,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wstrb,
  output logic [63:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        ld_valid,
  output logic [63:0] ld_data,
  output logic [4:0]  ld_rd,
  output logic        misalign_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wstrb_q, mem_wstrb_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  off_q, off_d;
  logic [6:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        ld_valid_q, ld_valid_d;
  logic [63:0] ld_data_q, ld_data_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        misalign_q, misalign_d;

  // Request legality and lane-placement signals, evaluated on the raw inputs.
  logic        accept;
  logic        len_ok;
  logic        align_ok;
  logic        op_onehot;
  logic [3:0]  op_size;
  logic        illegal;
  logic [7:0]  base_mask;
  logic [63:0] shifted;
  logic [63:0] extended;

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign mem_wdata     = mem_wdata_q;
  assign ld_valid      = ld_valid_q;
  assign ld_data       = ld_data_q;
  assign ld_rd         = ld_rd_q;
  assign misalign_err  = misalign_q;

  // Classify the incoming request: size, alignment and load-kind consistency.
  always_comb begin
    accept    = req_valid && req_ready;
    len_ok    = (wr_rd_mem_len == 4'd1) || (wr_rd_mem_len == 4'd2) ||
                (wr_rd_mem_len == 4'd4) || (wr_rd_mem_len == 4'd8);
    align_ok  = (({1'b0, addr[2:0]} & (wr_rd_mem_len - 4'd1)) == 4'd0);
    op_onehot = (rd_mem_op != 7'd0) && ((rd_mem_op & (rd_mem_op - 7'd1)) == 7'd0);
    op_size   = 4'd0;
    if (rd_mem_op[0])                      op_size = 4'd8;
    else if (rd_mem_op[1] || rd_mem_op[4]) op_size = 4'd4;
    else if (rd_mem_op[2] || rd_mem_op[5]) op_size = 4'd2;
    else if (rd_mem_op[3] || rd_mem_op[6]) op_size = 4'd1;
    illegal = (rd_mem_en && wr_mem_en) || !len_ok || !align_ok ||
              (rd_mem_en && !wr_mem_en && (!op_onehot || (op_size != wr_rd_mem_len)));
    base_mask = 8'h00;
    case (wr_rd_mem_len)
      4'd1:    base_mask = 8'h01;
      4'd2:    base_mask = 8'h03;
      4'd4:    base_mask = 8'h0F;
      4'd8:    base_mask = 8'hFF;
      default: base_mask = 8'h00;
    endcase
  end

  // Shift the returned doubleword down to the addressed field and extend it.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    extended = shifted;
    if (op_q[3])      extended = {{56{shifted[7]}},  shifted[7:0]};
    else if (op_q[2]) extended = {{48{shifted[15]}}, shifted[15:0]};
    else if (op_q[1]) extended = {{32{shifted[31]}}, shifted[31:0]};
    else if (op_q[6]) extended = {56'd0, shifted[7:0]};
    else if (op_q[5]) extended = {48'd0, shifted[15:0]};
    else if (op_q[4]) extended = {32'd0, shifted[31:0]};
  end

  // Next-state and next-register logic for the IDLE/REQ/WAIT_RSP sequence.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    op_d        = op_q;
    rd_d        = rd_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    ld_rd_d     = ld_rd_q;
    misalign_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && (rd_mem_en || wr_mem_en)) begin
          if (illegal) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_addr_d  = {addr[63:3], 3'b000};
            mem_we_d    = wr_mem_en;
            mem_wstrb_d = wr_mem_en ? (base_mask << addr[2:0]) : 8'h00;
            mem_wdata_d = wr_mem_en ? (wdata << {addr[2:0], 3'b000}) : 64'd0;
            off_d       = addr[2:0];
            op_d        = rd_mem_op;
            rd_d        = rd_idx;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = mem_we_q ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_d    = IDLE;
          ld_valid_d = 1'b1;
          ld_data_d  = extended;
          ld_rd_d    = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= 64'd0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 8'h00;
      mem_wdata_q <= 64'd0;
      off_q       <= 3'd0;
      op_q        <= 7'd0;
      rd_q        <= 5'd0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= 64'd0;
      ld_rd_q     <= 5'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      ld_rd_q     <= ld_rd_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_lsu_responder.sv
// Directed bench for lsu_responder: each task drives one scenario and checks
// the outputs against hand-computed values at the falling clock edge.
module tb_lsu_responder;

  localparam logic [6:0] OP_LD  = 7'b0000001;
  localparam logic [6:0] OP_LW  = 7'b0000010;
  localparam logic [6:0] OP_LH  = 7'b0000100;
  localparam logic [6:0] OP_LB  = 7'b0001000;
  localparam logic [6:0] OP_LWU = 7'b0010000;
  localparam logic [6:0] OP_LHU = 7'b0100000;
  localparam logic [6:0] OP_LBU = 7'b1000000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        rd_mem_en;
  logic        wr_mem_en;
  logic [3:0]  wr_rd_mem_len;
  logic [6:0]  rd_mem_op;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [4:0]  rd_idx;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic [4:0]  ld_rd;
  logic        misalign_err;
  logic        busy;

  int checks;
  int failures;
  int hs_count;

  lsu_responder dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rd_mem_en     (rd_mem_en),
    .wr_mem_en     (wr_mem_en),
    .wr_rd_mem_len (wr_rd_mem_len),
    .rd_mem_op     (rd_mem_op),
    .addr          (addr),
    .wdata         (wdata),
    .rd_idx        (rd_idx),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_rd         (ld_rd),
    .misalign_err  (misalign_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every memory handshake so transaction counts can be checked.
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) hs_count = hs_count + 1;
  end

  // Present one request for a single cycle, starting and ending at a falling edge.
  task automatic issue(input logic rd, input logic wr, input logic [3:0] len,
                       input logic [6:0] op, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] idx);
    rd_mem_en     = rd;
    wr_mem_en     = wr;
    wr_rd_mem_len = len;
    rd_mem_op     = op;
    addr          = a;
    wdata         = wd;
    rd_idx        = idx;
    req_valid     = 1'b1;
    @(negedge clk);
    req_valid     = 1'b0;
    rd_mem_en     = 1'b0;
    wr_mem_en     = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if ({mem_we, mem_wstrb} !== 9'd0) begin failures++; $display("[TB] FAIL reset_we_wstrb got=%h exp=0", {mem_we, mem_wstrb}); end
    checks++; if (mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin failures++; $display("[TB] FAIL reset_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    checks++; if ({ld_valid, ld_rd, misalign_err} !== 7'd0 || ld_data !== 64'd0) begin failures++; $display("[TB] FAIL reset_ld got=%b %h %h %b exp=0", ld_valid, ld_data, ld_rd, misalign_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_lb_sign();
    issue(1'b1, 1'b0, 4'd1, OP_LB, 64'h1003, 64'd0, 5'd5);
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h1000) begin failures++; $display("[TB] FAIL lb_req got=%b %h exp=1 1000", mem_req_valid, mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_wstrb !== 8'h00) begin failures++; $display("[TB] FAIL lb_we_wstrb got=%b %h exp=0 00", mem_we, mem_wstrb); end
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL lb_busy got=%b %b exp=0 1", req_ready, busy); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL lb_wait got=%b %b exp=0 1", mem_req_valid, busy); end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h0000_0000_8000_0000;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    checks++; if (ld_valid !== 1'b1 || ld_data !== 64'hFFFF_FFFF_FFFF_FF80 || ld_rd !== 5'd5) begin failures++; $display("[TB] FAIL lb_data got=%b %h %0d exp=1 ffffffffffffff80 5", ld_valid, ld_data, ld_rd); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL lb_done_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    checks++; if (ld_valid !== 1'b0 || ld_data !== 64'hFFFF_FFFF_FFFF_FF80 || ld_rd !== 5'd5) begin failures++; $display("[TB] FAIL lb_hold got=%b %h %0d exp=0 ffffffffffffff80 5", ld_valid, ld_data, ld_rd); end
  endtask

  task automatic test_sh_store();
    issue(1'b0, 1'b1, 4'd2, 7'd0, 64'h2006, 64'hABCD, 5'd0);
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h2000 || mem_we !== 1'b1) begin failures++; $display("[TB] FAIL sh_req got=%b %h %b exp=1 2000 1", mem_req_valid, mem_addr, mem_we); end
    checks++; if (mem_wstrb !== 8'hC0 || mem_wdata !== 64'hABCD_0000_0000_0000) begin failures++; $display("[TB] FAIL sh_lanes got=%h %h exp=c0 abcd000000000000", mem_wstrb, mem_wdata); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL sh_done got=%b %b %b exp=0 1 0", mem_req_valid, req_ready, busy); end
    checks++; if (ld_valid !== 1'b0) begin failures++; $display("[TB] FAIL sh_no_ld got=%b exp=0", ld_valid); end
  endtask

  task automatic test_stores();
    logic [3:0]  len_t [3];
    logic [63:0] a_t   [3];
    logic [63:0] wd_t  [3];
    logic [7:0]  st_t  [3];
    logic [63:0] ew_t  [3];
    len_t[0] = 4'd1; a_t[0] = 64'h8005; wd_t[0] = 64'h12;        st_t[0] = 8'h20; ew_t[0] = 64'h0000_1200_0000_0000;
    len_t[1] = 4'd4; a_t[1] = 64'h8004; wd_t[1] = 64'hDEADBEEF;  st_t[1] = 8'hF0; ew_t[1] = 64'hDEAD_BEEF_0000_0000;
    len_t[2] = 4'd8; a_t[2] = 64'h8008; wd_t[2] = 64'h0123_4567_89AB_CDEF; st_t[2] = 8'hFF; ew_t[2] = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, len_t[i], 7'd0, a_t[i], wd_t[i], 5'd0);
      checks++; if (mem_wstrb !== st_t[i] || mem_wdata !== ew_t[i] || mem_addr !== {a_t[i][63:3], 3'b000}) begin failures++; $display("[TB] FAIL store%0d got=%h %h %h exp=%h %h %h", i, mem_wstrb, mem_wdata, mem_addr, st_t[i], ew_t[i], {a_t[i][63:3], 3'b000}); end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
  endtask

  task automatic test_lw_misalign();
    int hs0;
    hs0 = hs_count;
    issue(1'b1, 1'b0, 4'd4, OP_LW, 64'h3002, 64'd0, 5'd3);
    checks++; if (misalign_err !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL lw_mis_pulse got=%b %b exp=1 0", misalign_err, mem_req_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL lw_mis_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    checks++; if (misalign_err !== 1'b0 || mem_req_valid !== 1'b0 || hs_count != hs0) begin failures++; $display("[TB] FAIL lw_mis_after got=%b %b hs=%0d exp=0 0 hs=%0d", misalign_err, mem_req_valid, hs_count, hs0); end
  endtask

  task automatic test_illegal();
    logic       rd_t  [5];
    logic       wr_t  [5];
    logic [3:0] len_t [5];
    logic [6:0] op_t  [5];
    logic [63:0] a_t  [5];
    rd_t[0] = 1; wr_t[0] = 1; len_t[0] = 4'd8; op_t[0] = OP_LD;         a_t[0] = 64'h6000;
    rd_t[1] = 1; wr_t[1] = 0; len_t[1] = 4'd4; op_t[1] = OP_LH;         a_t[1] = 64'h6000;
    rd_t[2] = 1; wr_t[2] = 0; len_t[2] = 4'd1; op_t[2] = OP_LB | OP_LH; a_t[2] = 64'h6000;
    rd_t[3] = 0; wr_t[3] = 1; len_t[3] = 4'd3; op_t[3] = 7'd0;          a_t[3] = 64'h6000;
    rd_t[4] = 0; wr_t[4] = 1; len_t[4] = 4'd8; op_t[4] = 7'd0;          a_t[4] = 64'h6004;
    for (int i = 0; i < 5; i++) begin
      issue(rd_t[i], wr_t[i], len_t[i], op_t[i], a_t[i], 64'h55, 5'd1);
      checks++; if (misalign_err !== 1'b1 || mem_req_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal%0d got=%b %b %b exp=1 0 0", i, misalign_err, mem_req_valid, busy); end
    end
    @(negedge clk);
  endtask

  task automatic test_noop();
    issue(1'b0, 1'b0, 4'd8, OP_LD, 64'h7000, 64'd0, 5'd2);
    checks++; if (misalign_err !== 1'b0 || mem_req_valid !== 1'b0 || busy !== 1'b0 || ld_valid !== 1'b0) begin failures++; $display("[TB] FAIL noop got=%b %b %b %b exp=0 0 0 0", misalign_err, mem_req_valid, busy, ld_valid); end
  endtask

  task automatic test_load_kinds();
    logic [6:0]  op_t  [6];
    logic [3:0]  len_t [6];
    logic [63:0] a_t   [6];
    logic [63:0] ex_t  [6];
    op_t[0] = OP_LBU; len_t[0] = 4'd1; a_t[0] = 64'h7001; ex_t[0] = 64'h0000_0000_0000_0097;
    op_t[1] = OP_LH;  len_t[1] = 4'd2; a_t[1] = 64'h7002; ex_t[1] = 64'hFFFF_FFFF_FFFF_B5A6;
    op_t[2] = OP_LHU; len_t[2] = 4'd2; a_t[2] = 64'h7006; ex_t[2] = 64'h0000_0000_0000_F1E2;
    op_t[3] = OP_LW;  len_t[3] = 4'd4; a_t[3] = 64'h7004; ex_t[3] = 64'hFFFF_FFFF_F1E2_D3C4;
    op_t[4] = OP_LWU; len_t[4] = 4'd4; a_t[4] = 64'h7000; ex_t[4] = 64'h0000_0000_B5A6_9788;
    op_t[5] = OP_LB;  len_t[5] = 4'd1; a_t[5] = 64'h7000; ex_t[5] = 64'hFFFF_FFFF_FFFF_FF88;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, len_t[i], op_t[i], a_t[i], 64'd0, 5'(10 + i));
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'hF1E2_D3C4_B5A6_9788;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      checks++; if (ld_valid !== 1'b1 || ld_data !== ex_t[i] || ld_rd !== 5'(10 + i)) begin failures++; $display("[TB] FAIL load%0d got=%b %h %0d exp=1 %h %0d", i, ld_valid, ld_data, ld_rd, ex_t[i], 10 + i); end
    end
    @(negedge clk);
  endtask

  task automatic test_ld_stall();
    int hs0;
    hs0 = hs_count;
    issue(1'b1, 1'b0, 4'd8, OP_LD, 64'h4000, 64'd0, 5'd7);
    for (int c = 0; c < 3; c++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h4000 || mem_we !== 1'b0 || mem_wstrb !== 8'h00 || mem_wdata !== 64'd0) begin failures++; $display("[TB] FAIL ld_stall%0d got=%b %h %b %h %h exp=1 4000 0 00 0", c, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata); end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (hs_count - hs0 != 1 || busy !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL ld_one_txn got=hs%0d %b %b exp=hs1 1 0", hs_count - hs0, busy, mem_req_valid); end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h1122_3344_5566_7788;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    checks++; if (ld_valid !== 1'b1 || ld_data !== 64'h1122_3344_5566_7788 || ld_rd !== 5'd7) begin failures++; $display("[TB] FAIL ld_data got=%b %h %0d exp=1 1122334455667788 7", ld_valid, ld_data, ld_rd); end
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_count;
    mem_req_ready = 1'b1;
    rd_mem_en = 1'b0; wr_mem_en = 1'b1; wr_rd_mem_len = 4'd8; rd_mem_op = 7'd0;
    addr = 64'h9000; wdata = 64'hA5A5_5A5A_0F0F_F0F0; rd_idx = 5'd0;
    req_valid = 1'b1;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1 || mem_wstrb !== 8'hFF || mem_wdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin failures++; $display("[TB] FAIL b2b_first got=%b %h %h exp=1 ff a5a55a5a0f0ff0f0", mem_req_valid, mem_wstrb, mem_wdata); end
    wr_rd_mem_len = 4'd1; addr = 64'h9001; wdata = 64'h5A;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_gap got=%b %b exp=0 1", mem_req_valid, req_ready); end
    @(negedge clk);
    req_valid = 1'b0; wr_mem_en = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h9000 || mem_wstrb !== 8'h02 || mem_wdata !== 64'h5A00) begin failures++; $display("[TB] FAIL b2b_second got=%b %h %h %h exp=1 9000 02 5a00", mem_req_valid, mem_addr, mem_wstrb, mem_wdata); end
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (hs_count - hs0 != 2 || busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_count got=hs%0d %b exp=hs2 0", hs_count - hs0, busy); end
  endtask

  task automatic test_reset_midflight();
    issue(1'b1, 1'b0, 4'd2, OP_LHU, 64'h5002, 64'd0, 5'd9);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_wait got=%b %b exp=1 0", busy, mem_req_valid); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || mem_addr !== 64'd0 || ld_data !== 64'd0) begin failures++; $display("[TB] FAIL mid_async got=%b %h %h exp=0 0 0", busy, mem_addr, ld_data); end
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hFFFF_0000_0000_0000;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    checks++; if (ld_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_late_rsp got=%b %b %b exp=0 0 1", ld_valid, busy, req_ready); end
    @(negedge clk);
    checks++; if (ld_valid !== 1'b0 || ld_data !== 64'd0 || ld_rd !== 5'd0) begin failures++; $display("[TB] FAIL mid_after got=%b %h %0d exp=0 0 0", ld_valid, ld_data, ld_rd); end
  endtask

  initial begin
    checks = 0; failures = 0; hs_count = 0;
    rst = 1'b1; req_valid = 1'b0; rd_mem_en = 1'b0; wr_mem_en = 1'b0;
    wr_rd_mem_len = 4'd0; rd_mem_op = 7'd0; addr = 64'd0; wdata = 64'd0; rd_idx = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'd0;
    test_reset();
    test_lb_sign();
    test_sh_store();
    test_stores();
    test_lw_misalign();
    test_illegal();
    test_noop();
    test_load_kinds();
    test_ld_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
